// File: rtl/npu_pkg.sv
// Shared widths, activation limits and the FIFO entry layout for the NPU activation path.
package npu_pkg;

  localparam int unsigned SUM_W    = 16;
  localparam int unsigned ACT_W    = 8;
  localparam int unsigned ACC_W    = 18;
  localparam int unsigned SHIFT_W  = 4;
  localparam int unsigned SATCNT_W = 16;
  localparam int          ACT_MAX  = 127;
  localparam int          ACT_MIN  = -128;

  typedef struct packed {
    logic             sat;
    logic [ACT_W-1:0] act;
  } act_entry_t;

endpackage

// File: rtl/npu_sync_fifo.sv
// Single-clock FIFO with occupancy count; Depth must be a power of two so pointers wrap freely.
module npu_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [Width-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [Width-1:0]       rd_data_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_fire, rd_fire;

  assign wr_fire = wr_en_i && (count_q != CntW'(Depth));
  assign rd_fire = rd_en_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_fire ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_fire && !rd_fire) begin
      count_d = count_q + CntW'(1);
    end else if (!wr_fire && rd_fire) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; emptiness is tracked by the pointers and count alone.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/neuron_activation.sv
// Bias add, optional ReLU, rounding requantisation and int8 saturation, buffered in an output FIFO.
module neuron_activation
  import npu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [SUM_W-1:0]       in_sum,
  input  logic signed [SUM_W-1:0]       bias,
  input  logic [SHIFT_W-1:0]            shift,
  input  logic                          relu_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACT_W-1:0]       out_act,
  output logic                          out_sat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          sat_clr,
  output logic [SATCNT_W-1:0]           sat_count
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [ACC_W-1:0] QMax = ACC_W'(ACT_MAX);
  localparam logic signed [ACC_W-1:0] QMin = ACC_W'(ACT_MIN);

  logic                    in_fire;
  logic                    s1_valid_q;
  logic signed [SUM_W:0]   s1_q, s1_d;
  logic [SHIFT_W-1:0]      shift_q;
  logic                    relu_q;
  logic signed [ACC_W-1:0] r_ext, rnd, q;
  act_entry_t              wr_entry, rd_entry;
  logic                    fifo_empty;
  logic [CntW:0]           credit_used;
  logic [SATCNT_W-1:0]     sat_count_q, sat_count_d;

  assign in_fire = in_valid && in_ready;
  assign s1_d    = {in_sum[SUM_W-1], in_sum} + {bias[SUM_W-1], bias};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
    end else begin
      s1_valid_q <= in_fire;
      if (in_fire) begin
        s1_q    <= s1_d;
        shift_q <= shift;
        relu_q  <= relu_en;
      end
    end
  end

  // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
  always_comb begin
    r_ext = {{(ACC_W - SUM_W - 1){s1_q[SUM_W]}}, s1_q};
    if (relu_q && s1_q[SUM_W]) begin
      r_ext = '0;
    end
    rnd = (shift_q == '0) ? '0 : (ACC_W'(1) << (shift_q - SHIFT_W'(1)));
    q   = (r_ext + rnd) >>> shift_q;

    wr_entry = '0;
    if (q > QMax) begin
      wr_entry.act = ACT_W'(ACT_MAX);
      wr_entry.sat = 1'b1;
    end else if (q < QMin) begin
      wr_entry.act = ACT_W'(ACT_MIN);
      wr_entry.sat = 1'b1;
    end else begin
      wr_entry.act = q[ACT_W-1:0];
    end
  end

  npu_sync_fifo #(
    .Width ($bits(act_entry_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .wr_en_i   (s1_valid_q),
    .wr_data_i (wr_entry),
    .rd_en_i   (out_ready),
    .rd_data_o (rd_entry),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Credit counts the result still in stage 1 so the FIFO can never overflow.
  assign credit_used = {1'b0, fifo_count} + {{CntW{1'b0}}, s1_valid_q};
  assign in_ready    = reset_n && (credit_used < (CntW + 1)'(FIFO_DEPTH));

  assign out_valid = !fifo_empty;
  assign out_act   = out_valid ? rd_entry.act : '0;
  assign out_sat   = out_valid ? rd_entry.sat : 1'b0;

  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (s1_valid_q && wr_entry.sat && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + SATCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;

endmodule

// File: doc/neuron_activation.md
NEURON_ACTIVATION -- requirements
Module: neuron_activation

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output FIFO entries (power of 2, >= 2).
REQ-002 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port in_valid  in  1  upstream neuron sum valid.
REQ-005 Port in_ready  out  1  block can accept in_sum this cycle.
REQ-006 Port in_sum  in  16  signed neuron sum, two's complement.
REQ-007 Port bias  in  16  signed bias, sampled with in_sum.
REQ-008 Port shift  in  4  unsigned requant right-shift, sampled with in_sum.
REQ-009 Port relu_en  in  1  1 = apply ReLU, sampled with in_sum.
REQ-010 Port out_valid  out  1  FIFO head holds a result.
REQ-011 Port out_ready  in  1  downstream accepts the head.
REQ-012 Port out_act  out  8  signed int8 activation at FIFO head.
REQ-013 Port out_sat  out  1  head result was clipped by saturation.
REQ-014 Port fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-015 Port sat_clr  in  1  synchronous clear of sat_count.
REQ-016 Port sat_count  out  16  saturating count of clipped results.

Function
REQ-017 Input transfer: in_valid && in_ready at a rising edge; out transfer: out_valid && out_ready at a rising edge.
REQ-018 Stage 1 (registered on input transfer): s1 = in_sum + bias, 17-bit signed, no overflow; shift and relu_en captured alongside.
REQ-019 Stage 2 (combinational on stage-1 regs, written to FIFO one edge later): r = (relu_en && s1<0) ? 0 : s1.
REQ-020 Rounding: q = (r + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, arithmetic, 18-bit intermediate (round half toward +inf).
REQ-021 Saturation: q>127 -> 127, q<-128 -> -128, out_sat=1 for that entry; else out_act=q[7:0], out_sat=0.
REQ-022 Latency: input accepted at edge k -> FIFO write at edge k+1 -> out_valid high after edge k+1 if FIFO was empty (2-cycle latency).
REQ-023 Pipeline never stalls: in_ready = (fifo_count + s1_valid) < FIFO_DEPTH (credit based); no result is ever dropped.
REQ-024 Full throughput: one input per cycle sustained while out_ready=1.
REQ-025 Simultaneous FIFO write and read: both occur, count unchanged, including at full and at empty with write (write-then-visible next cycle).
REQ-026 Results leave in exactly input order.
REQ-027 out_act/out_sat are 0 when out_valid=0.
REQ-028 sat_count increments by 1 on each FIFO write with out_sat=1; holds at 16'hFFFF; sat_clr wins over simultaneous increment.

Reset
REQ-029 reset_n low asynchronously empties the FIFO, clears stage-1 valid, sat_count=0, fifo_count=0, out_valid=0, out_act=0, out_sat=0.
REQ-030 in_ready is 0 while reset_n is low and 1 in the first cycle after deassertion; in-flight data at reset is discarded.

Structure
REQ-031 Shared package npu_pkg holds SUM_W=16, ACT_W=8, ACC_W=18, ACT_MAX=127, ACT_MIN=-128.
REQ-032 Output buffer is one sub-module npu_sync_fifo (parameterised width/depth, count output); arithmetic stays in neuron_activation.

Verification
REQ-033 in_sum=100, bias=20, shift=2, relu_en=0 -> out_act=30, out_sat=0, out_valid 2 cycles after acceptance.
REQ-034 in_sum=-300, bias=0, shift=0, relu_en=0 -> out_act=-128, out_sat=1, sat_count=1; same with relu_en=1 -> out_act=0, out_sat=0.
REQ-035 in_sum=-6, bias=0, shift=2 -> out_act=-1; in_sum=32767, bias=32767, shift=15 -> out_act=2.
REQ-036 out_ready=0, 6 back-to-back inputs 1..6 (shift=0), FIFO_DEPTH=4 -> in_ready low after 4 accepted; release out_ready -> 1..6 in order, none lost.
REQ-037 reset_n pulsed low with 3 entries queued -> out_valid=0, fifo_count=0, sat_count=0 immediately; first post-reset input emerges normally.
REQ-038 sat_count preloaded to 16'hFFFF by forced stimulus + further saturation -> stays FFFF; sat_clr with saturating write same cycle -> 0.
